// File: rtl/ws2812_pkg.sv
// Shared types and 12 MHz default timing for the WS2812 serializer family.
package ws2812_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    LATCH = 2'd2
  } state_e;

  // 1.25 us bit, 0.42/0.83 us high times, 300 us latch at 12 MHz
  localparam int unsigned DEF_PIX_BITS  = 24;
  localparam int unsigned DEF_BIT_CYC   = 15;
  localparam int unsigned DEF_T0H_CYC   = 5;
  localparam int unsigned DEF_T1H_CYC   = 10;
  localparam int unsigned DEF_RESET_CYC = 3600;

endpackage

// File: rtl/ws2812_bit_timer.sv
// One bit period of pulse-width coding: cycle counter and registered high/low level.
module ws2812_bit_timer #(
  parameter int unsigned BIT_CYC = 15,
  parameter int unsigned T0H_CYC = 5,
  parameter int unsigned T1H_CYC = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic run,
  input  logic bit_val,
  output logic level,
  output logic last_cycle,
  output logic penult_c
);

  localparam int unsigned K_W = $clog2(BIT_CYC);

  logic [K_W-1:0] k_q;
  logic [K_W-1:0] k_inc;
  logic [K_W-1:0] high_cyc;

  assign k_inc      = k_q + K_W'(1);
  assign high_cyc   = bit_val ? K_W'(T1H_CYC) : K_W'(T0H_CYC);
  assign last_cycle = (k_q == K_W'(BIT_CYC - 1));
  assign penult_c   = (k_q == K_W'(BIT_CYC - 2));

  // Level is computed for the coming cycle, so it is always 1 at k=0 (T0H >= 1)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q   <= '0;
      level <= 1'b0;
    end else if (start) begin
      k_q   <= '0;
      level <= 1'b1;
    end else if (run) begin
      k_q   <= k_inc;
      level <= (k_inc < high_cyc);
    end else begin
      k_q   <= '0;
      level <= 1'b0;
    end
  end

endmodule

// File: rtl/ws2812_pixel_tx.sv
// WS2812-class serializer: one pixel per handshake, MSB first, latch period at frame end.
module ws2812_pixel_tx
  import ws2812_pkg::*;
#(
  parameter int unsigned PIX_BITS  = DEF_PIX_BITS,
  parameter int unsigned BIT_CYC   = DEF_BIT_CYC,
  parameter int unsigned T0H_CYC   = DEF_T0H_CYC,
  parameter int unsigned T1H_CYC   = DEF_T1H_CYC,
  parameter int unsigned RESET_CYC = DEF_RESET_CYC
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PIX_BITS-1:0] pix_data,
  input  logic                pix_valid,
  output logic                pix_ready,
  output logic                busy,
  output logic                frame_done,
  output logic                ws_data,
  output logic                ws_data_n
);

  localparam int unsigned IDX_W = (PIX_BITS > 1) ? $clog2(PIX_BITS) : 1;
  localparam int unsigned LAT_W = (RESET_CYC > 1) ? $clog2(RESET_CYC) : 1;

  if (!(T0H_CYC >= 1 && T0H_CYC < T1H_CYC && T1H_CYC < BIT_CYC &&
        RESET_CYC >= 1 && PIX_BITS >= 1)) begin : g_param_check
    $error("ws2812_pixel_tx: illegal timing parameters");
  end

  state_e              state_q, state_d;
  logic [PIX_BITS-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic                ready_d;
  logic                done_d;
  logic                take;
  logic                tmr_start;
  logic                tmr_run;
  logic                last_cycle;
  logic                penult_c;
  logic                last_bit;

  assign take      = pix_valid & pix_ready;
  assign last_bit  = (idx_q == IDX_W'(PIX_BITS - 1));
  assign ws_data_n = ~ws_data;

  ws2812_bit_timer #(
    .BIT_CYC (BIT_CYC),
    .T0H_CYC (T0H_CYC),
    .T1H_CYC (T1H_CYC)
  ) u_bit_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (tmr_start),
    .run        (tmr_run),
    .bit_val    (shreg_q[PIX_BITS-1]),
    .level      (ws_data),
    .last_cycle (last_cycle),
    .penult_c   (penult_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      idx_q      <= '0;
      lat_q      <= '0;
      pix_ready  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      idx_q      <= idx_d;
      lat_q      <= lat_d;
      pix_ready  <= ready_d;
      busy       <= (state_d != IDLE);
      frame_done <= done_d;
    end
  end

  // Next state; registered outputs are derived from the coming state so they line up with ws_data
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    idx_d     = idx_q;
    lat_d     = lat_q;
    tmr_start = 1'b0;
    tmr_run   = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (take) begin
          state_d   = SEND;
          shreg_d   = pix_data;
          idx_d     = '0;
          tmr_start = 1'b1;
        end
      end
      SEND: begin
        if (!last_cycle) begin
          tmr_run = 1'b1;
        end else if (!last_bit) begin
          shreg_d   = shreg_q << 1;
          idx_d     = idx_q + IDX_W'(1);
          tmr_start = 1'b1;
        end else if (take) begin
          shreg_d   = pix_data;
          idx_d     = '0;
          tmr_start = 1'b1;
        end else begin
          state_d = LATCH;
          lat_d   = '0;
        end
      end
      LATCH: begin
        if (lat_q == LAT_W'(RESET_CYC - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Ready in IDLE, or in the final cycle of the final bit for gapless chaining
    ready_d = (state_d == IDLE) | (tmr_run & penult_c & last_bit);
  end

endmodule

// File: tb/tb_ws2812_pixel_tx.sv
// Directed bench for ws2812_pixel_tx using a per-cycle expected-waveform scoreboard.
module tb_ws2812_pixel_tx;

  localparam int unsigned PB = 8;
  localparam int unsigned BC = 6;
  localparam int unsigned T0 = 2;
  localparam int unsigned T1 = 4;
  localparam int unsigned RC = 10;

  typedef struct packed {
    logic ws;
    logic rdy;
    logic busy;
    logic done;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst_n, rst_n_b;
  logic [PB-1:0] pix_data;
  logic          pix_valid;
  logic          pix_ready, busy, frame_done, ws_data, ws_data_n;
  logic [23:0]   pix_data_b;
  logic          pix_valid_b;
  logic          pix_ready_b, busy_b, frame_done_b, ws_data_b, ws_data_n_b;

  int   total = 0;
  int   bad   = 0;
  obs_t exp_q[$];

  always #5 clk = ~clk;

  ws2812_pixel_tx #(
    .PIX_BITS (PB), .BIT_CYC (BC), .T0H_CYC (T0), .T1H_CYC (T1), .RESET_CYC (RC)
  ) dut (
    .clk (clk), .rst_n (rst_n), .pix_data (pix_data), .pix_valid (pix_valid),
    .pix_ready (pix_ready), .busy (busy), .frame_done (frame_done),
    .ws_data (ws_data), .ws_data_n (ws_data_n)
  );

  ws2812_pixel_tx dut_def (
    .clk (clk), .rst_n (rst_n_b), .pix_data (pix_data_b), .pix_valid (pix_valid_b),
    .pix_ready (pix_ready_b), .busy (busy_b), .frame_done (frame_done_b),
    .ws_data (ws_data_b), .ws_data_n (ws_data_n_b)
  );

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s t=%0t got ws/rdy/busy/done=%b want=%b", tag, $time, got, want);
    end
  endtask

  // Expected waveform of one pixel: high for T1H/T0H cycles of each bit, ready in the final cycle
  task automatic push_pixel(input logic [31:0] d, input int unsigned nb, input int unsigned bc,
                            input int unsigned t0, input int unsigned t1);
    obs_t e;
    for (int b = int'(nb) - 1; b >= 0; b--) begin
      for (int unsigned k = 0; k < bc; k++) begin
        e.ws   = (k < (d[b] ? t1 : t0));
        e.rdy  = (b == 0) && (k == bc - 1);
        e.busy = 1'b1;
        e.done = 1'b0;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic push_latch(input int unsigned rc);
    for (int unsigned i = 0; i < rc; i++) exp_q.push_back(obs_t'(4'b0010));
    exp_q.push_back(obs_t'(4'b0101));
  endtask

  // One clock: sample just after the edge and compare with the next expected entry (idle if none)
  task automatic step(input bit sel, input string tag);
    obs_t want;
    logic [3:0] got;
    @(posedge clk);
    #1;
    got  = sel ? {ws_data_b, pix_ready_b, busy_b, frame_done_b}
               : {ws_data, pix_ready, busy, frame_done};
    want = (exp_q.size() > 0) ? exp_q.pop_front() : obs_t'(4'b0100);
    check(tag, got, want);
  endtask

  task automatic drain(input bit sel, input string tag);
    while (exp_q.size() > 0) step(sel, tag);
    step(sel, {tag, "_idle"});
  endtask

  // Complementary pad output must track ws_data at all times
  always @(negedge clk) begin
    total++;
    assert (ws_data_n === ~ws_data) else begin
      bad++;
      $error("FAIL ws_data_n got=%b want=%b", ws_data_n, ~ws_data);
    end
    total++;
    assert (ws_data_n_b === ~ws_data_b) else begin
      bad++;
      $error("FAIL ws_data_n_def got=%b want=%b", ws_data_n_b, ~ws_data_b);
    end
  end

  initial begin
    rst_n = 1'b0; rst_n_b = 1'b0;
    pix_data = '0; pix_valid = 1'b0;
    pix_data_b = '0; pix_valid_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", {ws_data, pix_ready, busy, frame_done}, 4'b0000);
    check("reset_def", {ws_data_b, pix_ready_b, busy_b, frame_done_b}, 4'b0000);
    check("reset_n", {3'b000, ws_data_n}, 4'b0001);
    rst_n = 1'b1; rst_n_b = 1'b1;
    step(0, "post_reset");

    // Single pixel 0xA5
    pix_data = 8'hA5; pix_valid = 1'b1;
    push_pixel(32'hA5, PB, BC, T0, T1);
    push_latch(RC);
    step(0, "single");
    pix_valid = 1'b0; pix_data = 8'h3C;
    drain(0, "single");

    // Back-to-back 0xFF then 0x00 with valid held
    pix_data = 8'hFF; pix_valid = 1'b1;
    push_pixel(32'hFF, PB, BC, T0, T1);
    push_pixel(32'h00, PB, BC, T0, T1);
    push_latch(RC);
    step(0, "b2b");
    pix_data = 8'h00;
    repeat (PB * BC) step(0, "b2b");
    pix_valid = 1'b0; pix_data = 8'hC3;
    drain(0, "b2b");

    // Pixel offered during latch waits for IDLE
    pix_data = 8'h80; pix_valid = 1'b1;
    push_pixel(32'h80, PB, BC, T0, T1);
    push_latch(RC);
    push_pixel(32'h01, PB, BC, T0, T1);
    push_latch(RC);
    step(0, "holdoff");
    pix_valid = 1'b0;
    repeat (51) step(0, "holdoff");
    pix_valid = 1'b1; pix_data = 8'h01;
    repeat (8) step(0, "holdoff");
    pix_valid = 1'b0; pix_data = 8'hAA;
    drain(0, "holdoff");

    // Async reset at bit 3, k=1
    pix_data = 8'h5A; pix_valid = 1'b1;
    push_pixel(32'h5A, PB, BC, T0, T1);
    step(0, "pre_rst");
    pix_valid = 1'b0;
    repeat (3 * BC + 1) step(0, "pre_rst");
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("async_rst", {ws_data, pix_ready, busy, frame_done}, 4'b0000);
    check("async_rst_n", {3'b000, ws_data_n}, 4'b0001);
    @(posedge clk);
    #1;
    check("rst_hold", {ws_data, pix_ready, busy, frame_done}, 4'b0000);
    rst_n = 1'b1;
    repeat (3) step(0, "rst_release");
    pix_data = 8'h3C; pix_valid = 1'b1;
    push_pixel(32'h3C, PB, BC, T0, T1);
    push_latch(RC);
    step(0, "after_rst");
    pix_valid = 1'b0;
    drain(0, "after_rst");

    // Default 24-bit timing, pixel 0x800001
    step(1, "def_idle");
    pix_data_b = 24'h800001; pix_valid_b = 1'b1;
    push_pixel(32'h800001, 24, 15, 5, 10);
    push_latch(3600);
    step(1, "def");
    pix_valid_b = 1'b0;
    drain(1, "def");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
